shot_controller: RTL

//  Player-side initiator for the trajectory calculator. Captures button input to set launch x, rise, run and

---
 rtl/shot_controller_pkg.sv | 25 ++
 rtl/shot_controller_lfsr.sv | 21 ++
 rtl/shot_controller.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/shot_controller_pkg.sv
// Shared definitions for the shot controller and the trajectory calculator.
//   WIDTH     : coordinate / rise / run width
//   state_e   : controller FSM encoding
//   adj_sel_e : adjust-field select codes
//   RISE_MIN / FIELD_MAX : legal field limits (rise must stay nonzero)
package shot_controller_pkg;
  localparam int WIDTH     = 5;
  localparam int LFSR_W    = 10;
  localparam int RISE_MIN  = 1;
  localparam int FIELD_MAX = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SCORE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ADJ_X    = 2'b00,
    ADJ_RISE = 2'b01,
    ADJ_RUN  = 2'b10,
    ADJ_NONE = 2'b11
  } adj_sel_e;
endpackage

// File: rtl/shot_controller_lfsr.sv
// target_lfsr: free-running 10-bit Fibonacci LFSR, polynomial x^10+x^7+1.
//   clk, rst (async, active-high) ; lfsr_o : current register value.
// SEED must be nonzero or the register locks up at zero.
module target_lfsr
  import shot_controller_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 10'h2A5
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] lfsr_o
);
  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= {lfsr_q[LFSR_W-2:0], lfsr_q[9] ^ lfsr_q[6]};
  end

  assign lfsr_o = lfsr_q;
endmodule

// File: rtl/shot_controller.sv
// shot_controller: player-side initiator for the trajectory calculator.
//   Inputs : btn_fire, adj_sel/adj_up/adj_dn, dir_toggle (button levels, rising
//            edges act), result_valid/hit from the calculator.
//   Outputs: shoot pulse with x_pos/rise_out/run_out/direction held stable,
//            target_x/target_y, busy, saturating shots/hits, last_hit, timed_out.
// All outputs are registered; clk/rst (async, active-high).
module shot_controller
  import shot_controller_pkg::*;
#(
  parameter int                WIDTH     = shot_controller_pkg::WIDTH,
  parameter int                SCORE_W   = 8,
  parameter int                TIMEOUT   = 63,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 10'h2A5,
  parameter int                TGT_X0    = 20,
  parameter int                TGT_Y0    = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_fire,
  input  logic [1:0]         adj_sel,
  input  logic               adj_up,
  input  logic               adj_dn,
  input  logic               dir_toggle,
  input  logic               result_valid,
  input  logic               hit,
  output logic               shoot,
  output logic [WIDTH-1:0]   x_pos,
  output logic [WIDTH-1:0]   rise_out,
  output logic [WIDTH-1:0]   run_out,
  output logic               direction,
  output logic [WIDTH-1:0]   target_x,
  output logic [WIDTH-1:0]   target_y,
  output logic               busy,
  output logic [SCORE_W-1:0] shots,
  output logic [SCORE_W-1:0] hits,
  output logic               last_hit,
  output logic               timed_out
);
  localparam int              CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] F_MAX = WIDTH'(FIELD_MAX);
  localparam logic [WIDTH-1:0] R_MIN = WIDTH'(RISE_MIN);

  state_e              state_q;
  logic [CNT_W-1:0]    wcnt_q;
  logic                fire_p_q, up_p_q, dn_p_q, tog_p_q;
  logic                shoot_q, busy_q, dir_q, last_hit_q, timed_out_q;
  logic [WIDTH-1:0]    x_q, rise_q, run_q, tx_q, ty_q;
  logic [SCORE_W-1:0]  shots_q, hits_q;
  logic [LFSR_W-1:0]   lfsr;

  logic fire_e, up_e, dn_e, tog_e;
  assign fire_e = btn_fire   & ~fire_p_q;
  assign up_e   = adj_up     & ~up_p_q;
  assign dn_e   = adj_dn     & ~dn_p_q;
  assign tog_e  = dir_toggle & ~tog_p_q;

  target_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr)
  );

  // Saturating +/-1 within [lo, F_MAX].
  function automatic logic [WIDTH-1:0] sat_adj(input logic [WIDTH-1:0] v,
                                               input logic up,
                                               input logic [WIDTH-1:0] lo);
    if (up) return (v >= F_MAX) ? F_MAX : v + 1'b1;
    else    return (v <= lo)    ? lo    : v - 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      fire_p_q    <= 1'b0;
      up_p_q      <= 1'b0;
      dn_p_q      <= 1'b0;
      tog_p_q     <= 1'b0;
      shoot_q     <= 1'b0;
      busy_q      <= 1'b0;
      x_q         <= '0;
      rise_q      <= R_MIN;
      run_q       <= WIDTH'(1);
      dir_q       <= 1'b1;
      tx_q        <= WIDTH'(TGT_X0);
      ty_q        <= WIDTH'(TGT_Y0);
      shots_q     <= '0;
      hits_q      <= '0;
      last_hit_q  <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      fire_p_q <= btn_fire;
      up_p_q   <= adj_up;
      dn_p_q   <= adj_dn;
      tog_p_q  <= dir_toggle;
      shoot_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fire_e) begin
            // fire wins over any same-cycle adjust/toggle edge
            state_q <= ST_ISSUE;
            shoot_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            if (up_e ^ dn_e) begin
              case (adj_sel)
                ADJ_X:    x_q    <= sat_adj(x_q,    up_e, '0);
                ADJ_RISE: rise_q <= sat_adj(rise_q, up_e, R_MIN);
                ADJ_RUN:  run_q  <= sat_adj(run_q,  up_e, '0);
                default: ;
              endcase
            end
            if (tog_e) dir_q <= ~dir_q;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
          wcnt_q  <= '0;
        end
        ST_WAIT: begin
          wcnt_q <= wcnt_q + 1'b1;
          // Score is registered on the way into SCORE so it is visible there.
          // Timeout fires when the counter would reach TIMEOUT, i.e. after
          // exactly TIMEOUT cycles spent in WAIT.
          if (result_valid || wcnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q     <= ST_SCORE;
            shots_q     <= (shots_q == '1) ? shots_q : shots_q + 1'b1;
            last_hit_q  <= result_valid & hit;
            timed_out_q <= ~result_valid;
            if (result_valid && hit) begin
              hits_q <= (hits_q == '1) ? hits_q : hits_q + 1'b1;
              tx_q   <= lfsr[4:0];
              ty_q   <= lfsr[9:5];
            end
          end
        end
        ST_SCORE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign shoot     = shoot_q;
  assign busy      = busy_q;
  assign x_pos     = x_q;
  assign rise_out  = rise_q;
  assign run_out   = run_q;
  assign direction = dir_q;
  assign target_x  = tx_q;
  assign target_y  = ty_q;
  assign shots     = shots_q;
  assign hits      = hits_q;
  assign last_hit  = last_hit_q;
  assign timed_out = timed_out_q;
endmodule
